// File: rtl/shift_left_unit.sv
// Registered left shifter for the branch/offset path: scales the sign-extended
// immediate by a programmable power of two, one cycle of latency, and flags
// when the scaled value no longer fits as a signed WIDTH-bit quantity.
module shift_left_unit #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] signExtendedR2,
    input  logic        [SHW-1:0]   shamt,
    input  logic                    validIn,
    output logic signed [WIDTH-1:0] shiftedOut,
    output logic                    validOut,
    output logic                    overflow
);

    // Signed overflow of op << amt: every discarded bit and the new MSB must
    // match the original sign bit. Shifts of WIDTH or more leave nothing, so
    // any non-zero operand overflows.
    function automatic logic calcOverflow(input logic signed [WIDTH-1:0] op,
                                          input logic        [SHW-1:0]   amt);
        logic ovf;
        ovf = 1'b0;
        if (int'(amt) >= WIDTH) begin
            ovf = (op != '0);
        end else begin
            for (int i = 0; i < WIDTH - 1; i++) begin
                if ((i + int'(amt)) >= (WIDTH - 1) && (op[i] != op[WIDTH-1])) begin
                    ovf = 1'b1;
                end
            end
        end
        return ovf;
    endfunction

    logic signed [WIDTH-1:0] shifted_p0;
    logic                    ovf_p0;

    logic signed [WIDTH-1:0] result_p1;
    logic                    ovf_p1;
    logic                    vld_p1;

    // Stage 0: log2 barrel shifter, stage k shifts by 2**k when shamt[k] is set
    always_comb begin
        shifted_p0 = signExtendedR2;
        for (int k = 0; k < SHW; k++) begin
            if (shamt[k]) begin
                shifted_p0 = shifted_p0 << (1 << k);
            end
        end
    end

    // Stage 0: overflow detection on the unshifted operand
    always_comb begin
        ovf_p0 = calcOverflow(signExtendedR2, shamt);
    end

    // Stage 0 -> 1: capture on qualified cycles, hold result otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_p1 <= '0;
            ovf_p1    <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= validIn;
            if (validIn) begin
                result_p1 <= shifted_p0;
                ovf_p1    <= ovf_p0;
            end
        end
    end

    assign shiftedOut = result_p1;
    assign overflow   = ovf_p1;
    assign validOut   = vld_p1;

endmodule

// File: tb/tb_shift_left_unit.sv
// Scoreboard bench for shift_left_unit: stimulus pushes expected results,
// a negedge monitor pops and compares whenever validOut is high.
module tb_shift_left_unit;

    localparam int WIDTH = 16;
    localparam int SHW   = 4;

    logic               clk;
    logic               rst;
    logic [WIDTH-1:0]   signExtendedR2;
    logic [SHW-1:0]     shamt;
    logic               validIn;
    logic [WIDTH-1:0]   shiftedOut;
    logic               validOut;
    logic               overflow;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             ovf;
    } exp_t;

    exp_t sbq[$];
    exp_t lastExp;
    bit   haveLast;

    int compared;
    int mismatched;

    shift_left_unit #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk            (clk),
        .rst            (rst),
        .signExtendedR2 (signExtendedR2),
        .shamt          (shamt),
        .validIn        (validIn),
        .shiftedOut     (shiftedOut),
        .validOut       (validOut),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: multiply by 2**s as a signed integer; the low WIDTH bits are
    // the result, and overflow means the product leaves the signed range.
    function automatic exp_t model(input logic [WIDTH-1:0] d, input int s);
        exp_t   e;
        longint v;
        longint p;
        v = longint'($signed(d));
        p = v * (longint'(1) <<< s);
        e.data = WIDTH'(p);
        e.ovf  = (p > ((longint'(1) <<< (WIDTH-1)) - 1)) || (p < -(longint'(1) <<< (WIDTH-1)));
        return e;
    endfunction

    task automatic issue(input logic [WIDTH-1:0] d, input int s);
        signExtendedR2 = d;
        shamt          = SHW'(s);
        validIn        = 1'b1;
        sbq.push_back(model(d, s));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [WIDTH-1:0] d);
        signExtendedR2 = d;
        validIn        = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare on every valid output; outside valid cycles
    // the registers must hold the last captured result.
    always @(negedge clk) begin
        if (rst) begin
            haveLast = 1'b0;
        end else if (validOut) begin
            if (sbq.size() == 0) begin
                check("unexpected_valid", 32'(validOut), 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("shiftedOut", 32'(shiftedOut), 32'(e.data));
                check("overflow", 32'(overflow), 32'(e.ovf));
                lastExp  = e;
                haveLast = 1'b1;
            end
        end else if (haveLast) begin
            check("hold_shiftedOut", 32'(shiftedOut), 32'(lastExp.data));
            check("hold_overflow", 32'(overflow), 32'(lastExp.ovf));
        end
    end

    initial begin
        compared       = 0;
        mismatched     = 0;
        haveLast       = 1'b0;
        rst            = 1'b1;
        signExtendedR2 = '0;
        shamt          = '0;
        validIn        = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_shiftedOut", 32'(shiftedOut), 32'h0);
        check("reset_validOut", 32'(validOut), 32'h0);
        check("reset_overflow", 32'(overflow), 32'h0);
        rst = 1'b0;

        // Mid-operation async reset: capture a result, then clear it between edges
        signExtendedR2 = 16'hC000;
        shamt          = 4'd2;
        validIn        = 1'b1;
        @(posedge clk);
        #1;
        check("pre_rst_validOut", 32'(validOut), 32'h1);
        check("pre_rst_shiftedOut", 32'(shiftedOut), 32'h0000);
        check("pre_rst_overflow", 32'(overflow), 32'h1);
        validIn = 1'b0;
        rst     = 1'b1;
        #1;
        check("async_rst_shiftedOut", 32'(shiftedOut), 32'h0);
        check("async_rst_validOut", 32'(validOut), 32'h0);
        check("async_rst_overflow", 32'(overflow), 32'h0);
        validIn        = 1'b1;
        signExtendedR2 = 16'h00FF;
        @(posedge clk);
        #1;
        check("held_rst_shiftedOut", 32'(shiftedOut), 32'h0);
        check("held_rst_validOut", 32'(validOut), 32'h0);
        validIn = 1'b0;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Standard offset path
        issue(16'h0005, 1);
        issue(16'h0013, 1);
        issue(16'h0007, 1);
        // Negative operands and overflow
        issue(16'hFFFB, 1);
        issue(16'h8000, 1);
        issue(16'h4000, 1);
        // Range ends
        issue(16'h1234, 0);
        issue(16'h0001, 15);
        issue(16'hFFFF, 15);

        // Hold: result stays while validIn is low and the operand changes
        issue(16'h0013, 1);
        for (int i = 0; i < 3; i++) begin
            idle(16'hAAAA);
            check("hold_directed_data", 32'(shiftedOut), 32'h0026);
            check("hold_directed_valid", 32'(validOut), 32'h0);
        end

        // Back-to-back captures
        issue(16'h0001, 1);
        issue(16'h0001, 2);
        issue(16'h0001, 3);
        check("b2b_valid", 32'(validOut), 32'h1);
        check("b2b_last", 32'(shiftedOut), 32'h0008);

        // Randomized traffic with random gaps
        for (int n = 0; n < 300; n++) begin
            logic [WIDTH-1:0] d;
            int               s;
            d = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0: d = 16'hFFFF;
                1: d = WIDTH'($urandom_range(0, 3)) << $urandom_range(12, 15);
                default: ;
            endcase
            s = int'($urandom_range(0, WIDTH-1));
            if ($urandom_range(0, 2) != 0) begin
                issue(d, s);
            end else begin
                signExtendedR2 = d;
                shamt          = SHW'(s);
                idle(d);
            end
        end

        idle(16'h0000);
        idle(16'h0000);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
